// File: rtl/acia_uart_if.sv
// CPU-side register bus of the ACIA UART: chip select, direction, register select,
// write data in, registered read data and the level IRQ back to the CPU.
interface acia_uart_if;
    logic       cs;
    logic       we;
    logic       rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (output cs, output we, output rs, output din, input dout, input irq);
    modport slave  (input cs, input we, input rs, input din, output dout, output irq);
endinterface

// File: rtl/acia_uart.sv
// 6502-bus-mapped 8N1 UART with registered read data and level IRQ.
// Define ACIA_RX_FIFO_EN to replace the single RX holding register with a FIFO_DEPTH-entry FIFO.
module acia_uart #(
    parameter int BAUD_DIV   = 139,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    acia_uart_if.slave bus,
    input  logic       rx_i,
    output logic       tx_o
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic rd_stat, rd_data, wr_ctrl, wr_data, soft_rst, rst;

    assign rd_stat  = bus.cs & ~bus.we & ~bus.rs;
    assign rd_data  = bus.cs & ~bus.we &  bus.rs;
    assign wr_ctrl  = bus.cs &  bus.we & ~bus.rs;
    assign wr_data  = bus.cs &  bus.we &  bus.rs;
    // A control write with b7 set resets everything except the control bits it writes.
    assign soft_rst = wr_ctrl & bus.din[7];
    assign rst      = reset_i | soft_rst;

    logic [1:0] ctrl_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctrl_q <= 2'b00;
        end else if (wr_ctrl) begin
            ctrl_q <= bus.din[1:0];
        end
    end

    logic [7:0]  hold_q;
    logic        hold_full_q;
    logic        tx_busy_q;
    logic [8:0]  tx_sh_q;
    logic [3:0]  tx_bit_q;
    logic [15:0] tx_cnt_q;
    logic        tx_q;
    logic        tx_end, tx_load;

    assign tx_end  = tx_busy_q && (tx_cnt_q == 16'd0) && (tx_bit_q == 4'd9);
    assign tx_load = hold_full_q && (!tx_busy_q || tx_end);

    always_ff @(posedge clk_i) begin
        if (rst) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_busy_q   <= 1'b0;
            tx_sh_q     <= 9'h1FF;
            tx_bit_q    <= 4'd0;
            tx_cnt_q    <= 16'd0;
            tx_q        <= 1'b1;
        end else begin
            if (wr_data && !hold_full_q) begin
                hold_q      <= bus.din;
                hold_full_q <= 1'b1;
            end else if (tx_load) begin
                hold_full_q <= 1'b0;
            end

            // Loading straight from the stop bit's last clock gives gapless back-to-back frames.
            if (tx_load) begin
                tx_busy_q <= 1'b1;
                tx_q      <= 1'b0;
                tx_sh_q   <= {1'b1, hold_q};
                tx_bit_q  <= 4'd0;
                tx_cnt_q  <= BAUD_LAST;
            end else if (tx_busy_q) begin
                if (tx_cnt_q == 16'd0) begin
                    if (tx_bit_q == 4'd9) begin
                        tx_busy_q <= 1'b0;
                    end else begin
                        tx_q     <= tx_sh_q[0];
                        tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                        tx_bit_q <= tx_bit_q + 4'd1;
                        tx_cnt_q <= BAUD_LAST;
                    end
                end else begin
                    tx_cnt_q <= tx_cnt_q - 16'd1;
                end
            end
        end
    end

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_sh_q;
    logic        rx_push_q, rx_ferr_q;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= BAUD_HALF;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                        rx_cnt_q   <= BAUD_LAST;
                        rx_bit_q   <= 3'd0;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_cnt_q <= BAUD_LAST;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_push_q  <= rx_s2_q;
                        rx_ferr_q  <= ~rx_s2_q;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    logic       rx_full, rx_avail, rx_push, rx_pop;
    logic [7:0] rx_head;

`ifdef ACIA_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;

    assign rx_full  = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign rx_avail = (count_q != '0);
    assign rx_head  = mem_q[rptr_q];
    assign rx_push  = rx_push_q & ~rx_full;
    assign rx_pop   = rd_data & rx_avail;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (rx_push) begin
                mem_q[wptr_q] <= rx_sh_q;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (rx_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic [7:0] rx_hold_q;
    logic       rx_valid_q;

    assign rx_full  = rx_valid_q;
    assign rx_avail = rx_valid_q;
    assign rx_head  = rx_hold_q;
    assign rx_push  = rx_push_q & ~rx_full;
    assign rx_pop   = rd_data & rx_avail;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            rx_hold_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else if (rx_push) begin
            rx_hold_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
        end else if (rx_pop) begin
            rx_valid_q <= 1'b0;
        end
    end
`endif

    logic       ovr_q, ferr_q, irq_q, irq_d;
    logic [7:0] dout_q, status_d;

    assign irq_d    = (ctrl_q[0] & rx_avail) | (ctrl_q[1] & ~hold_full_q) | ovr_q | ferr_q;
    assign status_d = {irq_q, 3'b000, ferr_q, ovr_q, ~hold_full_q, rx_avail};

    always_ff @(posedge clk_i) begin
        if (rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            irq_q  <= 1'b0;
            dout_q <= 8'h00;
        end else begin
            // Set beats the clear from a simultaneous status read.
            ovr_q  <= (rx_push_q & rx_full) | (ovr_q & ~rd_stat);
            ferr_q <= rx_ferr_q | (ferr_q & ~rd_stat);
            irq_q  <= irq_d;
            if (rd_stat) begin
                dout_q <= status_d;
            end else if (rd_data) begin
                dout_q <= rx_avail ? rx_head : 8'h00;
            end
        end
    end

    assign bus.dout = dout_q;
    assign bus.irq  = irq_q;
    assign tx_o     = tx_q;
endmodule
